// File: rtl/rr_arbiter_4_pkg.sv
// Shared types, state encoding and helpers for the 4-way round-robin arbiter.
// Imported by the arbiter top, its picker and its bus interface.
package rr_arbiter_4_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef logic [NUM_REQ-1:0] req_t;
   typedef logic [IDX_W-1:0]   idx_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Pointer value after reset: the search then starts at requester 0.
   localparam idx_t LAST_RESET = idx_t'(NUM_REQ - 1);

   // 2-to-4 decode with enable; a disabled decode yields all zeros.
   function automatic req_t decode_idx(input idx_t idx, input logic en);
      return en ? (req_t'(1) << idx) : '0;
   endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_4_if;
   import rr_arbiter_4_pkg::*;

   logic enable;
   req_t req;
   req_t grant;
   idx_t grant_idx;
   logic grant_valid;

   modport master (
      output enable,
      output req,
      input  grant,
      input  grant_idx,
      input  grant_valid
   );

   modport slave (
      input  enable,
      input  req,
      output grant,
      output grant_idx,
      output grant_valid
   );

endinterface

// File: rtl/rr_pick_4.sv
// Rotating-priority search: first set request at or after start_i (mod 4),
// optionally skipping one index.
module rr_pick_4
   import rr_arbiter_4_pkg::*;
(
   input  req_t req_i,
   input  idx_t start_i,
   input  logic exclude_en_i,
   input  idx_t exclude_idx_i,
   output logic found_o,
   output idx_t pick_idx_o
);

   idx_t cand;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the loop can leave it unassigned and infer a latch.
   always_comb begin
      found_o    = 1'b0;
      pick_idx_o = '0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = start_i + idx_t'(i);
         if (!found_o && req_i[cand] && !(exclude_en_i && (cand == exclude_idx_i))) begin
            found_o    = 1'b1;
            pick_idx_o = cand;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a hold-time limit; all outputs are
// registered and the one-hot grant is the gated decode of grant_idx.
module rr_arbiter_4
   import rr_arbiter_4_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
)
(
   input logic            clk,
   input logic            reset,
   rr_arbiter_4_if.slave  bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_e           state_q, state_d;
   idx_t             owner_q, owner_d;
   idx_t             last_q,  last_d;
   logic [CNT_W-1:0] hold_q,  hold_d;
   logic             valid_q, valid_d;
   req_t             grant_q, grant_d;

   logic found;
   idx_t pick;
   logic take;

   // While busy, last_q equals the owner, so one picker serves both the idle
   // search (from last+1) and the handoff search (from owner+1, owner skipped).
   rr_pick_4 u_pick (
      .req_i         (bus.req),
      .start_i       (last_q + idx_t'(1)),
      .exclude_en_i  (state_q == ST_BUSY),
      .exclude_idx_i (owner_q),
      .found_o       (found),
      .pick_idx_o    (pick)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      hold_d  = hold_q;
      valid_d = valid_q;
      take    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            if (bus.enable && found) begin
               take = 1'b1;
            end
         end
         ST_BUSY: begin
            if (!bus.enable) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else if (!bus.req[owner_q]) begin
               // Owner released: hand off with no idle bubble, or go idle.
               if (found) begin
                  take = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
               end
            end else if ((hold_q == HOLD_LAST) && found) begin
               take = 1'b1;
            end else if (hold_q != HOLD_LAST) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase

      if (take) begin
         state_d = ST_BUSY;
         owner_d = pick;
         last_d  = pick;
         hold_d  = '0;
         valid_d = 1'b1;
      end

      grant_d = decode_idx(owner_d, valid_d);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         last_q  <= LAST_RESET;
         hold_q  <= '0;
         valid_q <= 1'b0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         grant_q <= grant_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = owner_q;
   assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench: three arbiters (MAX_HOLD 8, 4, 1) share one stimulus and
// are compared against directed expectations and an ownership/tenure model.
module tb_rr_arbiter_4;

   localparam int NINST = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] rq;
   bit         started = 1'b0;

   logic [3:0] obs_grant [NINST];
   logic [1:0] obs_idx   [NINST];
   logic       obs_valid [NINST];

   int checks   = 0;
   int failures = 0;

   // Model: owner (-1 = nobody), last granted index, cycles owned so far.
   int m_owner [NINST];
   int m_last  [NINST];
   int m_ten   [NINST];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NINST; k++) begin : g_dut
      localparam int H = (k == 0) ? 8 : (k == 1) ? 4 : 1;
      rr_arbiter_4_if bus ();
      assign bus.enable = en;
      assign bus.req    = rq;
      rr_arbiter_4 #(.MAX_HOLD(H), .CNT_W(4)) dut (
         .clk   (clk),
         .reset (rst),
         .bus   (bus)
      );
      assign obs_grant[k] = bus.grant;
      assign obs_idx[k]   = bus.grant_idx;
      assign obs_valid[k] = bus.grant_valid;
   end

   function automatic int hold_of(input int k);
      return (k == 0) ? 8 : (k == 1) ? 4 : 1;
   endfunction

   function automatic int next_after(input int p, input logic [3:0] mask);
      for (int d = 1; d <= 4; d++) begin
         if (mask[(p + d) % 4]) return (p + d) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_grant(input int k);
      logic [3:0] g;
      g = 4'b0000;
      if (m_owner[k] >= 0) g[m_owner[k]] = 1'b1;
      return g;
   endfunction

   task automatic give(input int k, input int w);
      m_owner[k] = w;
      m_last[k]  = w;
      m_ten[k]   = 1;
   endtask

   task automatic model_step(input int k);
      logic [3:0] others;
      if (rst) begin
         m_owner[k] = -1;
         m_last[k]  = 3;
         m_ten[k]   = 0;
      end else if (m_owner[k] < 0) begin
         if (en && rq != 4'b0000) give(k, next_after(m_last[k], rq));
      end else begin
         others = rq;
         others[m_owner[k]] = 1'b0;
         if (!en) begin
            m_owner[k] = -1;
         end else if (!rq[m_owner[k]] || (m_ten[k] >= hold_of(k) && others != 4'b0000)) begin
            if (others != 4'b0000) give(k, next_after(m_owner[k], others));
            else m_owner[k] = -1;
         end else begin
            m_ten[k]++;
         end
      end
   endtask

   task automatic tick();
      for (int k = 0; k < NINST; k++) model_step(k);
      @(posedge clk);
      #1;
      started = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One-hot-or-zero must hold on every cycle for every instance.
   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < NINST; k++) begin
            checks++;
            if (!$onehot0(obs_grant[k])) begin
               failures++;
               $display("FAIL onehot0 inst%0d: grant=%b", k, obs_grant[k]);
            end
         end
      end
   end

   task automatic test_reset();
      en  = 1'b1;
      rq  = 4'b1111;
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         for (int k = 0; k < NINST; k++) begin
            checks += 3;
            if (obs_grant[k] !== 4'b0000 || obs_valid[k] !== 1'b0 || obs_idx[k] !== 2'd0) begin
               failures++;
               $display("FAIL reset_outputs inst%0d: grant=%b valid=%b idx=%0d want 0000/0/0",
                        k, obs_grant[k], obs_valid[k], obs_idx[k]);
            end
         end
      end
      rst = 1'b0;
      rq  = 4'b0100;
      tick();
      for (int k = 0; k < NINST; k++) begin
         checks++;
         if (obs_grant[k] !== 4'b0100 || obs_idx[k] !== 2'd2 || obs_valid[k] !== 1'b1) begin
            failures++;
            $display("FAIL first_grant inst%0d: grant=%b idx=%0d valid=%b want 0100/2/1",
                     k, obs_grant[k], obs_idx[k], obs_valid[k]);
         end
      end
   endtask

   task automatic test_fairness();
      en = 1'b1;
      rq = 4'b1111;
      do_reset();
      for (int t = 0; t < 15; t++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_valid[k] !== 1'b1 || obs_idx[k] !== 2'((t / 3) % 4)) begin
               failures++;
               $display("FAIL fairness inst%0d t=%0d: idx=%0d valid=%b want %0d/1",
                        k, t, obs_idx[k], obs_valid[k], (t / 3) % 4);
            end
         end
         checks++;
         if (obs_grant[2] !== exp_grant(2)) begin
            failures++;
            $display("FAIL fairness_h1 t=%0d: grant=%b want %b", t, obs_grant[2], exp_grant(2));
         end
         rq = 4'b1111;
         if (m_ten[0] == 3) rq[m_owner[0]] = 1'b0;
      end
   endtask

   task automatic test_hold_limit();
      logic [3:0] want;
      en = 1'b1;
      rq = 4'b0011;
      do_reset();
      for (int t = 0; t < 16; t++) begin
         tick();
         for (int k = 0; k < NINST; k++) begin
            want = ((t / hold_of(k)) % 2 == 0) ? 4'b0001 : 4'b0010;
            checks++;
            if (obs_grant[k] !== want) begin
               failures++;
               $display("FAIL hold_rotate inst%0d t=%0d: grant=%b want %b", k, t, obs_grant[k], want);
            end
         end
      end
      rq = 4'b0001;
      for (int t = 0; t < 24; t++) begin
         tick();
         for (int k = 0; k < NINST; k++) begin
            checks++;
            if (obs_grant[k] !== 4'b0001) begin
               failures++;
               $display("FAIL lone_hold inst%0d t=%0d: grant=%b want 0001", k, t, obs_grant[k]);
            end
         end
      end
      rq = 4'b0011;
      tick();
      for (int k = 0; k < NINST; k++) begin
         checks++;
         if (obs_grant[k] !== 4'b0010) begin
            failures++;
            $display("FAIL saturated_rotate inst%0d: grant=%b want 0010", k, obs_grant[k]);
         end
      end
   endtask

   task automatic test_release_idle();
      en = 1'b1;
      rq = 4'b0000;
      do_reset();
      rq = 4'b0010;
      tick();
      rq = 4'b0000;
      tick();
      for (int k = 0; k < NINST; k++) begin
         checks++;
         if (obs_grant[k] !== 4'b0000 || obs_valid[k] !== 1'b0) begin
            failures++;
            $display("FAIL release_idle inst%0d: grant=%b valid=%b want 0000/0",
                     k, obs_grant[k], obs_valid[k]);
         end
      end
      rq = 4'b1001;
      tick();
      for (int k = 0; k < NINST; k++) begin
         checks++;
         if (obs_grant[k] !== 4'b1000 || obs_idx[k] !== 2'd3) begin
            failures++;
            $display("FAIL idle_priority inst%0d: grant=%b idx=%0d want 1000/3",
                     k, obs_grant[k], obs_idx[k]);
         end
      end
   endtask

   task automatic test_enable_reset();
      en = 1'b1;
      rq = 4'b0000;
      do_reset();
      rq = 4'b0010;
      tick();
      en = 1'b0;
      tick();
      for (int k = 0; k < NINST; k++) begin
         checks++;
         if (obs_grant[k] !== 4'b0000 || obs_valid[k] !== 1'b0) begin
            failures++;
            $display("FAIL disable_drop inst%0d: grant=%b valid=%b want 0000/0",
                     k, obs_grant[k], obs_valid[k]);
         end
      end
      en = 1'b1;
      rq = 4'b0011;
      tick();
      rq = 4'b0010;
      tick();
      for (int k = 0; k < NINST; k++) begin
         checks++;
         if (obs_grant[k] !== 4'b0010) begin
            failures++;
            $display("FAIL reenable_handoff inst%0d: grant=%b want 0010", k, obs_grant[k]);
         end
      end
      rst = 1'b1;
      tick();
      for (int k = 0; k < NINST; k++) begin
         checks++;
         if (obs_grant[k] !== 4'b0000 || obs_valid[k] !== 1'b0 || obs_idx[k] !== 2'd0) begin
            failures++;
            $display("FAIL midgrant_reset inst%0d: grant=%b valid=%b idx=%0d want 0000/0/0",
                     k, obs_grant[k], obs_valid[k], obs_idx[k]);
         end
      end
      rst = 1'b0;
      rq  = 4'b1111;
      tick();
      for (int k = 0; k < NINST; k++) begin
         checks++;
         if (obs_grant[k] !== 4'b0001) begin
            failures++;
            $display("FAIL pointer_reset inst%0d: grant=%b want 0001", k, obs_grant[k]);
         end
      end
   endtask

   task automatic test_wrap();
      en = 1'b1;
      rq = 4'b0000;
      do_reset();
      rq = 4'b1000;
      tick();
      rq = 4'b0101;
      tick();
      for (int k = 0; k < NINST; k++) begin
         checks++;
         if (obs_idx[k] !== 2'd0 || obs_grant[k] !== 4'b0001 || obs_valid[k] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_handoff inst%0d: grant=%b idx=%0d valid=%b want 0001/0/1",
                     k, obs_grant[k], obs_idx[k], obs_valid[k]);
         end
      end
   endtask

   task automatic test_random();
      en = 1'b1;
      rq = 4'b0000;
      do_reset();
      for (int t = 0; t < 800; t++) begin
         rst = ($urandom_range(0, 99) == 0);
         en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
         tick();
         for (int k = 0; k < NINST; k++) begin
            checks += 2;
            if (obs_grant[k] !== exp_grant(k) || obs_valid[k] !== (m_owner[k] >= 0)) begin
               failures++;
               $display("FAIL random inst%0d t=%0d: grant=%b valid=%b want %b/%b",
                        k, t, obs_grant[k], obs_valid[k], exp_grant(k), m_owner[k] >= 0);
            end
            if (m_owner[k] >= 0) begin
               checks++;
               if (obs_idx[k] !== 2'(m_owner[k])) begin
                  failures++;
                  $display("FAIL random_idx inst%0d t=%0d: idx=%0d want %0d",
                           k, t, obs_idx[k], m_owner[k]);
               end
            end
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      rq  = 4'b0000;
      for (int k = 0; k < NINST; k++) begin
         m_owner[k] = -1;
         m_last[k]  = 3;
         m_ten[k]   = 0;
      end
      test_reset();
      test_fairness();
      test_hold_limit();
      test_release_idle();
      test_enable_reset();
      test_wrap();
      test_random();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter with hold-time limiting.
- Shares one downstream resource (bus, memory port, datapath slot) among 4 requesters.
- Presents the winner both as a 2-bit index and as a one-hot grant vector. The one-hot vector is the 2-to-4 decode of the index, gated by grant_valid.
- Sits between requester logic and the shared resource's select/enable inputs.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one requester keeps the grant while others are waiting. Legal range is 1..2^CNT_W.
- CNT_W, 4: width of the hold counter.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: global arbitration enable. When low, no grant is issued.
- req, input, 4: request lines, one per requester. Level-sensitive.
- grant, output, 4: one-hot grant. Equals decode(grant_idx) when grant_valid=1, else 4'b0000.
- grant_idx, output, 2: index of the current owner.
- grant_valid, output, 1: a grant is active.

Behaviour:
- All outputs are registered.
- Reset (reset=1 at a clk edge), regardless of state:
  - state=IDLE, grant=0000, grant_idx=00, grant_valid=0, hold_cnt=0.
  - last pointer=2'd3, so req[0] has top priority first.
  - A reset mid-grant drops the grant on the next edge.
- Priority: the search order starts at last+1 and wraps modulo 4. Example: last=3 gives order 0,1,2,3; last=1 gives order 2,3,0,1.
- State IDLE:
  - If enable=1 and req!=0, pick the first set req in search order.
  - Next edge: state=BUSY, grant_idx=winner, grant_valid=1, last=winner, hold_cnt=0.
  - Latency from req to grant is 1 cycle.
- State BUSY, owner o, evaluated each edge in this priority order:
  1. enable=0: go to IDLE, grant_valid=0, grant=0000. last is kept.
  2. req[o]=0 (owner released):
     - If other req bits are set, hand off directly to the next requester in search order from o+1. There is no idle bubble, and hold_cnt=0.
     - If no other req bits are set, go to IDLE with grant cleared.
  3. req[o]=1, hold_cnt==MAX_HOLD-1, and at least one other req is set: forced rotation. Hand off to the next requester in search order from o+1, excluding o, with hold_cnt=0.
  4. Otherwise keep the grant. hold_cnt increments and saturates at MAX_HOLD-1.
- A lone requester keeps the grant indefinitely. Its counter stays saturated, and it rotates as soon as another request appears while saturated. That rotation takes effect on the edge after the new request is seen.
- MAX_HOLD=1: with others waiting, ownership rotates every cycle.
- All 4 requesting continuously: grants cycle 0,1,2,3,0,... with MAX_HOLD cycles each.
- Simultaneous owner release and a new request from another requester: a normal handoff per rule 2.
- Invariants:
  - grant is always one-hot or zero.
  - grant never changes except on a clk edge.
  - No requester whose req is low is ever newly granted.

Decomposition:
- Shared constants header (`include file, shared by arbiters/decoders):
  - State encodings ST_IDLE=1'b0, ST_BUSY=1'b1.
  - NUM_REQ=4, IDX_W=2.
- One natural sub-module, rr_pick_4 (combinational):
  - Inputs: req[3:0], start[1:0], exclude_en, exclude_idx[1:0].
  - Outputs: found, pick_idx[1:0].
  - Function: rotating-priority search.
- One-hot generation: a small 2-to-4 decode with enable, either inline or as a tiny instance, with grant_valid as the enable.

Test Plan:
1. Reset then single request: assert reset 2 cycles, then req=0100, enable=1. Expect grant=0100, grant_idx=2, grant_valid=1 one cycle later. Outputs are 0 during reset.
2. Round-robin fairness: MAX_HOLD=8, req=1111 held, each owner drops its req for 1 cycle after 3 cycles of ownership. Expect grant_idx sequence 0,1,2,3,0 with no gap cycles between owners.
3. Hold limit: MAX_HOLD=4, req=0011 held constantly. Expect grant=0001 for exactly 4 cycles, then 0010 for 4, then 0001, and so on. With req=0001 only, grant=0001 persists beyond 20 cycles.
4. Release to idle: owner 1 drops req with no others pending. Expect grant=0000 and grant_valid=0 next cycle. A later req=1000 gives grant=1000 (last=1, search order 2,3,0,1).
5. Enable and reset mid-grant: while grant=0010, deassert enable. Expect grant=0000 next cycle, and re-enable with req=0011 gives grant=0001. Repeat the setup but pulse reset mid-grant instead. Expect outputs zeroed next edge and the pointer back to 3.
6. Wrap and simultaneous events: owner 3 releases in the same cycle that req[0] and req[2] rise. Expect handoff to grant_idx=0 on the next edge, and a one-hot/zero assertion that holds every cycle.
